// File: rtl/vram_fetch.sv
// vram_fetch -- six-plane VRAM fetch engine with optional CPU access port.
//
// On a pixel strobe (vclk) whose address differs from the last one fetched,
// reads six plane bytes from six VRAM banks. The bytes are staged in shadow
// registers and then published on v1..v6 together on a single clock edge.
// Video fetches always win over CPU accesses. A fetch that is requested while
// the engine is busy is held as a single pending request. A later request
// replaces it.
//
// Build option: define VRAM_FETCH_CPU_EN to enable the CPU access path. When
// it is undefined, the CPU ports still exist but the inputs are ignored, and
// cpu_ack, cpu_rdata and ram_we stay at 0.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   vclk, vdp_addr[12:0]    pixel strobe and requested byte address
//   ram_addr[15:0]          VRAM address {bank, byte address}
//   ram_rd / ram_we         VRAM read / write strobes (read data one cycle later)
//   ram_wdata / ram_rdata   VRAM write / read data
//   v1..v6                  committed plane bytes
//   fetch_busy              fetch sequence in progress (FETCH or COMMIT)
//   cpu_req/we/addr/wdata   CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack      CPU read data and one-cycle completion pulse
module vram_fetch #(
  parameter logic [2:0] PLANE_BANK = 3'd1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vclk,
  input  logic [12:0] vdp_addr,
  output logic [15:0] ram_addr,
  output logic        ram_rd,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  v1,
  output logic [7:0]  v2,
  output logic [7:0]  v3,
  output logic [7:0]  v4,
  output logic [7:0]  v5,
  output logic [7:0]  v6,
  output logic        fetch_busy,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack
);

  typedef enum logic [2:0] {
    IDLE, FETCH, COMMIT
`ifdef VRAM_FETCH_CPU_EN
    , CPU_RD, CPU_WR
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q;          // plane index being read, 0..5
  logic [12:0] fetch_addr_q;
  logic [12:0] last_addr_q;
  logic        valid_q;
  logic        pend_q;
  logic [12:0] pend_addr_q;
  logic [7:0]  shadow_q [5];   // planes 1..5; plane 6 goes straight to v6
  logic [7:0]  v_q [6];
  logic        need;
  logic        start;
  logic [12:0] start_addr;
  logic [2:0]  bank;

`ifdef VRAM_FETCH_CPU_EN
  logic        ack_q;
  logic        ack_rd_q;
  logic [7:0]  rdata_q;
`endif

  assign need = vclk && (!valid_q || (vdp_addr != last_addr_q));
  assign bank = PLANE_BANK + cnt_q;

  // NOTE: every variable written in an always_comb gets a default first.
  // Without the defaults, an unassigned path would infer a latch.
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    start_addr = vdp_addr;
    case (state_q)
      IDLE, COMMIT: begin
        // A fresh request is newer than any pending one, so it wins.
        if (need) begin
          start = 1'b1;
        end else if (pend_q) begin
          start      = 1'b1;
          start_addr = pend_addr_q;
        end else if (state_q == COMMIT) begin
          state_d = IDLE;
        end
`ifdef VRAM_FETCH_CPU_EN
        // The ack cycle is spent in IDLE and never grants. That forces one
        // idle cycle between CPU accesses while cpu_req is still held.
        else if (cpu_req && !ack_q) begin
          state_d = cpu_we ? CPU_WR : CPU_RD;
        end
`endif
      end
      FETCH:   if (cnt_q == 3'd5) state_d = COMMIT;
      default: state_d = IDLE;
    endcase
    if (start) state_d = FETCH;
  end

  always_comb begin
    ram_addr  = '0;
    ram_rd    = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (state_q)
      FETCH: begin
        ram_rd   = 1'b1;
        ram_addr = {bank, fetch_addr_q};
      end
`ifdef VRAM_FETCH_CPU_EN
      CPU_RD: begin
        ram_rd   = 1'b1;
        ram_addr = cpu_addr;
      end
      CPU_WR: begin
        ram_we    = 1'b1;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
`endif
      default: ;
    endcase
  end

  assign fetch_busy = (state_q == FETCH) || (state_q == COMMIT);

  // NOTE: sequential state uses non-blocking assignments. Every register
  // then samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fetch_addr_q <= '0;
      last_addr_q  <= '0;
      valid_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      for (int i = 0; i < 6; i++) v_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        fetch_addr_q <= start_addr;
        cnt_q        <= '0;
      end else if (state_q == FETCH) begin
        cnt_q <= cnt_q + 3'd1;
      end
      if (need) begin
        last_addr_q <= vdp_addr;
        valid_q     <= 1'b1;
      end
      if (start) begin
        pend_q <= 1'b0;
      end else if (need) begin
        pend_q      <= 1'b1;
        pend_addr_q <= vdp_addr;
      end
      if (state_q == COMMIT) begin
        for (int i = 0; i < 5; i++) v_q[i] <= shadow_q[i];
        v_q[5] <= ram_rdata;
      end
    end
  end

  // NOTE: the shadow bytes have no reset. Each one is rewritten during a
  // fetch before COMMIT reads it, and a reset aborts any fetch in flight.
  always_ff @(posedge clk) begin
    if (state_q == FETCH && cnt_q != 3'd0) shadow_q[cnt_q - 3'd1] <= ram_rdata;
  end

  assign v1 = v_q[0];
  assign v2 = v_q[1];
  assign v3 = v_q[2];
  assign v4 = v_q[3];
  assign v5 = v_q[4];
  assign v6 = v_q[5];

`ifdef VRAM_FETCH_CPU_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q    <= 1'b0;
      ack_rd_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ack_q    <= (state_q == CPU_RD) || (state_q == CPU_WR);
      ack_rd_q <= (state_q == CPU_RD);
      if (ack_rd_q) rdata_q <= ram_rdata;
    end
  end

  // Read data arrives in the ack cycle. It is passed through then and held
  // afterwards.
  assign cpu_ack   = ack_q;
  assign cpu_rdata = ack_rd_q ? ram_rdata : rdata_q;
`else
  logic unused_cpu;
  assign unused_cpu = ^{cpu_req, cpu_we, cpu_addr, cpu_wdata};
  assign cpu_ack    = 1'b0;
  assign cpu_rdata  = '0;
`endif

endmodule

// File: tb/tb_vram_fetch.sv
module tb_vram_fetch;
  localparam logic [2:0] PB = 3'd1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vclk;
  logic [12:0] vdp_addr;
  logic [15:0] ram_addr;
  logic        ram_rd, ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;
  logic [7:0]  v1, v2, v3, v4, v5, v6;
  logic        fetch_busy;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [47:0] vcat;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  mem [0:65535];
  logic [12:0] m_last = '0;
  bit          m_valid = 1'b0;
  logic [47:0] m_vcat = '0;

  vram_fetch #(.PLANE_BANK(PB)) dut (
    .clk(clk), .reset_n(reset_n), .vclk(vclk), .vdp_addr(vdp_addr),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .v1(v1), .v2(v2), .v3(v3), .v4(v4), .v5(v5), .v6(v6),
    .fetch_busy(fetch_busy), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack)
  );

  assign vcat = {v1, v2, v3, v4, v5, v6};

  always #5 clk = ~clk;

  // Synchronous VRAM: read data valid the cycle after the strobe
  always @(posedge clk) begin
    if (ram_rd) ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read and write strobes are exclusive, and writes never happen during a fetch
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      check("rd_we_exclusive", {63'd0, ram_rd & ram_we}, 64'd0);
      check("we_in_fetch", {63'd0, ram_we & fetch_busy}, 64'd0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] plane_addr(input logic [12:0] a, input int k);
    logic [2:0] b;
    b = PB + 3'(k - 1);
    return {b, a};
  endfunction

  function automatic logic [47:0] planes(input logic [12:0] a);
    logic [47:0] r;
    r = '0;
    for (int k = 1; k <= 6; k++) r = {r[39:0], mem[plane_addr(a, k)]};
    return r;
  endfunction

  // Pulse vclk with address a, then check the full T+1..T+8 window against the model
  task automatic run_fetch(input logic [12:0] a);
    bit          exp_f;
    logic [47:0] old_v, new_v;
    exp_f = !m_valid || (a != m_last);
    old_v = m_vcat;
    new_v = exp_f ? planes(a) : old_v;
    vdp_addr = a;
    vclk = 1'b1;
    tick;
    vclk = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("fetch_rd", {63'd0, ram_rd}, {63'd0, exp_f});
      if (exp_f) check("fetch_addr", {48'd0, ram_addr}, {48'd0, plane_addr(a, k)});
      check("fetch_busy", {63'd0, fetch_busy}, {63'd0, exp_f});
      tick;
    end
    @(negedge clk);
    check("commit_busy", {63'd0, fetch_busy}, {63'd0, exp_f});
    check("no_partial", {16'd0, vcat}, {16'd0, old_v});
    tick;
    @(negedge clk);
    check("v_out", {16'd0, vcat}, {16'd0, new_v});
    check("busy_end", {63'd0, fetch_busy}, 64'd0);
    if (exp_f) begin
      m_last  = a;
      m_valid = 1'b1;
      m_vcat  = new_v;
    end
    tick;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [12:0] a, b, c;
    logic [47:0] va;

    reset_n = 1'b0; vclk = 1'b0; vdp_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int k = 1; k <= 6; k++) mem[plane_addr(13'h0EC0, k)] = 8'(8'h11 * k);
    mem[16'h1234] = 8'hA5;

    // Reset state
    tick; tick;
    @(negedge clk);
    check("rst_v", {16'd0, vcat}, 64'd0);
    check("rst_ram_addr", {48'd0, ram_addr}, 64'd0);
    check("rst_ram_wdata", {56'd0, ram_wdata}, 64'd0);
    check("rst_strobes", {60'd0, ram_rd, ram_we, cpu_ack, fetch_busy}, 64'd0);
    check("rst_cpu_rdata", {56'd0, cpu_rdata}, 64'd0);
    tick;
    reset_n = 1'b1;
    tick;

    // First fetch after reset, then a repeat of the same address
    run_fetch(13'h0EC0);
    check("first_fetch_v", {16'd0, vcat}, {16'd0, 48'h112233445566});
    run_fetch(13'h0EC0);
    check("repeat_no_change", {16'd0, vcat}, {16'd0, 48'h112233445566});

    // Overlapping request at T+3 becomes pending and starts at T+8
    a = 13'h0EC2;
    b = 13'h0EC1;
    va = planes(a);
    vdp_addr = a;
    vclk = 1'b1;
    tick;
    vclk = 1'b0;
    for (int c7 = 1; c7 <= 7; c7++) begin
      if (c7 == 3) begin
        vdp_addr = b;
        vclk = 1'b1;
      end
      @(negedge clk);
      check("ovl_rd", {63'd0, ram_rd}, {63'd0, c7 <= 6});
      if (c7 <= 6) check("ovl_addr", {48'd0, ram_addr}, {48'd0, plane_addr(a, c7)});
      check("ovl_busy", {63'd0, fetch_busy}, 64'd1);
      tick;
      vclk = 1'b0;
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) check("ovl_first_commit", {16'd0, vcat}, {16'd0, va});
      check("ovl2_rd", {63'd0, ram_rd}, 64'd1);
      check("ovl2_addr", {48'd0, ram_addr}, {48'd0, plane_addr(b, k)});
      tick;
    end
    @(negedge clk);
    check("ovl2_no_partial", {16'd0, vcat}, {16'd0, va});
    tick;
    @(negedge clk);
    check("ovl2_commit", {16'd0, vcat}, {16'd0, planes(b)});
    check("ovl2_busy_end", {63'd0, fetch_busy}, 64'd0);
    m_last = b; m_valid = 1'b1; m_vcat = planes(b);
    tick;

    // Randomized non-overlapping pixel strobes, including repeats and edges
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: a = m_last;
        1: a = 13'h0000;
        2: a = 13'h1FFF;
        default: a = 13'($urandom_range(0, 8191));
      endcase
      run_fetch(a);
      repeat ($urandom_range(0, 3)) tick;
    end

    // Reset at T+4 of a fetch aborts it
    c = (m_last == 13'h0ABC) ? 13'h0ABD : 13'h0ABC;
    vdp_addr = c;
    vclk = 1'b1;
    tick;
    vclk = 1'b0;
    tick; tick; tick;
    reset_n = 1'b0;
    #1;
    check("midrst_v", {16'd0, vcat}, 64'd0);
    check("midrst_strobes", {62'd0, ram_rd, fetch_busy}, 64'd0);
    tick; tick;
    reset_n = 1'b1;
    m_valid = 1'b0;
    m_vcat = '0;
    repeat (10) tick;
    @(negedge clk);
    check("midrst_no_commit", {16'd0, vcat}, 64'd0);
    check("midrst_idle", {63'd0, fetch_busy}, 64'd0);
    tick;
    run_fetch(c);

`ifdef VRAM_FETCH_CPU_EN
    // CPU read while idle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    @(negedge clk);
    check("cpurd_wait", {62'd0, ram_rd, cpu_ack}, 64'd0);
    tick;
    @(negedge clk);
    check("cpurd_strobe", {62'd0, ram_rd, ram_we}, 64'd2);
    check("cpurd_addr", {48'd0, ram_addr}, 64'h1234);
    check("cpurd_noack", {63'd0, cpu_ack}, 64'd0);
    tick;
    @(negedge clk);
    check("cpurd_ack", {63'd0, cpu_ack}, 64'd1);
    check("cpurd_data", {56'd0, cpu_rdata}, 64'hA5);
    check("cpurd_gap", {62'd0, ram_rd, ram_we}, 64'd0);
    tick;
    cpu_req = 1'b0;
    @(negedge clk);
    check("cpurd_ack_end", {63'd0, cpu_ack}, 64'd0);
    tick;

    // CPU write and vclk in the same idle cycle: the fetch goes first
    a = (m_last == 13'h0333) ? 13'h0334 : 13'h0333;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3456; cpu_wdata = 8'h5A;
    vdp_addr = a;
    vclk = 1'b1;
    tick;
    vclk = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("arb_we_low", {63'd0, ram_we}, 64'd0);
      check("arb_noack", {63'd0, cpu_ack}, 64'd0);
      if (k <= 6) check("arb_fetch_addr", {48'd0, ram_addr}, {48'd0, plane_addr(a, k)});
      tick;
    end
    @(negedge clk);
    check("arb_commit", {16'd0, vcat}, {16'd0, planes(a)});
    check("arb_we_after", {63'd0, ram_we}, 64'd0);
    m_last = a; m_vcat = planes(a);
    tick;
    @(negedge clk);
    check("arb_we", {62'd0, ram_rd, ram_we}, 64'd1);
    check("arb_we_addr", {48'd0, ram_addr}, 64'h3456);
    check("arb_we_data", {56'd0, ram_wdata}, 64'h5A);
    tick;
    @(negedge clk);
    check("arb_ack", {63'd0, cpu_ack}, 64'd1);
    check("arb_we_end", {63'd0, ram_we}, 64'd0);
    tick;
    cpu_req = 1'b0;
    @(negedge clk);
    check("arb_ack_end", {63'd0, cpu_ack}, 64'd0);
    tick;
`else
    // CPU path disabled: requests are ignored
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3456; cpu_wdata = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("nocpu_strobes", {61'd0, ram_rd, ram_we, cpu_ack}, 64'd0);
      check("nocpu_rdata", {56'd0, cpu_rdata}, 64'd0);
      tick;
    end
    cpu_we = 1'b0; cpu_addr = 16'h1234;
    repeat (3) begin
      @(negedge clk);
      check("nocpu_rd", {61'd0, ram_rd, ram_we, cpu_ack}, 64'd0);
      tick;
    end
    cpu_req = 1'b0;
`endif

    // Video still works after the CPU traffic
    run_fetch(13'h0EC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
